mux_4to1: RTL and testbench

- 4-input, 1-output data selector. The 2-bit select S picks one of four data inputs D0..D3.
- Provides two outputs:
  - a combinational output Y, for glue-logic use;
  - a registered output y_q with a valid flag, for pipelined datapaths.
- Sits in the adder/multiplexer datapath library as a generic leaf cell.

---
 rtl/mux_4to1_if.sv | 39 +++
 rtl/mux_4to1.sv | 68 ++++++
 tb/tb_mux_4to1.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_4to1_if.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4to1_if
//  Description : Bus bundle for the 4:1 data selector leaf cell.
//                master side drives select, data and in_valid; slave side
//                (the selector) returns the combinational and registered
//                results.
//  Signals     : S        - 2-bit select (00->D0 .. 11->D3)
//                D0..D3   - DATA_W-bit data inputs
//                in_valid - qualifies S/D for capture into the register
//                Y        - combinational selected data
//                y_q      - registered selected data
//                y_valid  - one-cycle flag following a captured in_valid
//  Revision    : 1.0 - initial release
// ============================================================================
interface mux_4to1_if #(
   parameter int DATA_W = 1
);
   logic [1:0]        S;
   logic [DATA_W-1:0] D0;
   logic [DATA_W-1:0] D1;
   logic [DATA_W-1:0] D2;
   logic [DATA_W-1:0] D3;
   logic              in_valid;
   logic [DATA_W-1:0] Y;
   logic [DATA_W-1:0] y_q;
   logic              y_valid;

   modport master (
      output S, D0, D1, D2, D3, in_valid,
      input  Y, y_q, y_valid
   );

   modport slave (
      input  S, D0, D1, D2, D3, in_valid,
      output Y, y_q, y_valid
   );
endinterface
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4to1
//  Description : Generic 4:1 data selector with a zero-latency combinational
//                output and an independent one-cycle registered output with
//                a valid flag.
//  Ports       : clk - rising-edge clock for the registered path
//                rst - synchronous, active-high reset
//                bus - mux_4to1_if.slave (S, D0..D3, in_valid in;
//                      Y, y_q, y_valid out)
//  Parameters  : DATA_W  - data width, 1..64
//                RST_VAL - reset value of y_q, truncated/zero-extended
//                          to DATA_W
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4to1 #(
   parameter int          DATA_W  = 1,
   parameter logic [63:0] RST_VAL = 64'd0
) (
   input  wire           clk,
   input  wire           rst,
   mux_4to1_if.slave     bus
);

   // Reset value reduced to the data width once, so the register sees a
   // correctly sized constant whatever DATA_W is.
   localparam logic [DATA_W-1:0] RST_Q = RST_VAL[DATA_W-1:0];

   logic [DATA_W-1:0] sel_data;
   logic [DATA_W-1:0] y_q_reg;
   logic              y_valid_reg;

   // Selection shared by both paths. The default arm is only reachable when
   // S carries X/Z in simulation; it drives X rather than silently falling
   // back to D0, so an unknown select is visible downstream.
   always_comb begin
      sel_data = {DATA_W{1'bx}};
      case (bus.S)
         2'b00:   sel_data = bus.D0;
         2'b01:   sel_data = bus.D1;
         2'b10:   sel_data = bus.D2;
         2'b11:   sel_data = bus.D3;
         default: sel_data = {DATA_W{1'bx}};
      endcase
   end

   // Registered path: reset wins over in_valid, so a capture presented in a
   // reset cycle is dropped. Without in_valid the data holds and the flag
   // clears, giving a single-cycle valid per accepted input.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q_reg     <= RST_Q;
         y_valid_reg <= 1'b0;
      end else begin
         y_valid_reg <= bus.in_valid;
         if (bus.in_valid) begin
            y_q_reg <= sel_data;
         end
      end
   end

   // Y is taken straight from the selector, never from the register.
   assign bus.Y       = sel_data;
   assign bus.y_q     = y_q_reg;
   assign bus.y_valid = y_valid_reg;

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_4to1
//  Description : Self-checking bench for mux_4to1. Three instances:
//                  a - DATA_W=8,  RST_VAL=0
//                  b - DATA_W=1,  RST_VAL=2 (truncates to 0)
//                  c - DATA_W=12, RST_VAL=64'hABC_DEF (truncates to 12'hDEF)
//                Expected values come from a behavioural model: the selected
//                word is d[s], and the register is an "on each edge" rule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4to1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mux_4to1_if #(.DATA_W(8))  a_if ();
   mux_4to1_if #(.DATA_W(1))  b_if ();
   mux_4to1_if #(.DATA_W(12)) c_if ();

   mux_4to1 #(.DATA_W(8),  .RST_VAL(64'h0))       u_a (.clk(clk), .rst(rst), .bus(a_if.slave));
   mux_4to1 #(.DATA_W(1),  .RST_VAL(64'h2))       u_b (.clk(clk), .rst(rst), .bus(b_if.slave));
   mux_4to1 #(.DATA_W(12), .RST_VAL(64'hABC_DEF)) u_c (.clk(clk), .rst(rst), .bus(c_if.slave));

   int checks = 0;
   int errors = 0;

   // Stimulus state (values are kept pre-masked to each instance's width)
   logic [63:0] a_d [4];
   logic [63:0] b_d [4];
   logic [63:0] c_d [4];
   logic [1:0]  a_s = 2'd0, b_s = 2'd0, c_s = 2'd0;
   logic        a_v = 1'b0, b_v = 1'b0, c_v = 1'b0;

   // Reference model of the registered path
   logic [63:0] a_q, b_q, c_q;
   logic        a_qv, b_qv, c_qv;

   always @(posedge clk) begin
      if (rst) begin
         a_q <= 64'h0;   a_qv <= 1'b0;
         b_q <= 64'h0;   b_qv <= 1'b0;
         c_q <= 64'hDEF; c_qv <= 1'b0;
      end else begin
         if (a_v) a_q <= a_d[a_s];
         if (b_v) b_q <= b_d[b_s];
         if (c_v) c_q <= c_d[c_s];
         a_qv <= a_v;
         b_qv <= b_v;
         c_qv <= c_v;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic apply();
      a_if.S = a_s; a_if.in_valid = a_v;
      a_if.D0 = a_d[0][7:0]; a_if.D1 = a_d[1][7:0];
      a_if.D2 = a_d[2][7:0]; a_if.D3 = a_d[3][7:0];
      b_if.S = b_s; b_if.in_valid = b_v;
      b_if.D0 = b_d[0][0]; b_if.D1 = b_d[1][0];
      b_if.D2 = b_d[2][0]; b_if.D3 = b_d[3][0];
      c_if.S = c_s; c_if.in_valid = c_v;
      c_if.D0 = c_d[0][11:0]; c_if.D1 = c_d[1][11:0];
      c_if.D2 = c_d[2][11:0]; c_if.D3 = c_d[3][11:0];
   endtask

   task automatic check_comb(input string tag);
      check({tag, "_aY"}, 64'(a_if.Y), a_d[a_s]);
      check({tag, "_bY"}, 64'(b_if.Y), b_d[b_s]);
      check({tag, "_cY"}, 64'(c_if.Y), c_d[c_s]);
   endtask

   task automatic check_regs(input string tag);
      check({tag, "_aq"}, 64'(a_if.y_q), a_q);
      check({tag, "_av"}, 64'(a_if.y_valid), 64'(a_qv));
      check({tag, "_bq"}, 64'(b_if.y_q), b_q);
      check({tag, "_bv"}, 64'(b_if.y_valid), 64'(b_qv));
      check({tag, "_cq"}, 64'(c_if.y_q), c_q);
      check({tag, "_cv"}, 64'(c_if.y_valid), 64'(c_qv));
   endtask

   // Advance one clock and check the registered outputs 1 ns after the edge.
   task automatic tick(input string tag);
      @(posedge clk);
      #1;
      check_regs(tag);
   endtask

   task automatic randomize_inputs(input logic rand_valid);
      for (int i = 0; i < 4; i++) begin
         a_d[i] = 64'($urandom & 32'hFF);
         b_d[i] = 64'($urandom & 32'h1);
         c_d[i] = 64'($urandom & 32'hFFF);
      end
      a_s = 2'($urandom); b_s = 2'($urandom); c_s = 2'($urandom);
      if (rand_valid) begin
         a_v = 1'($urandom); b_v = 1'($urandom); c_v = 1'($urandom);
      end
   endtask

   initial begin
      // Fixed patterns: a = 11/22/33/44, b = 0/1/0/1, c = random
      a_d[0] = 64'h11; a_d[1] = 64'h22; a_d[2] = 64'h33; a_d[3] = 64'h44;
      b_d[0] = 64'h0;  b_d[1] = 64'h1;  b_d[2] = 64'h0;  b_d[3] = 64'h1;
      for (int i = 0; i < 4; i++) c_d[i] = 64'($urandom & 32'hFFF);

      // Reset held 2 cycles with in_valid=1, S=11: capture must be dropped
      rst = 1'b1;
      a_s = 2'd3; a_v = 1'b1;
      c_s = 2'd3; c_v = 1'b1;
      apply();
      tick("rst1");
      check("rst1_aq_const", 64'(a_if.y_q), 64'h0);
      check("rst1_cq_trunc", 64'(c_if.y_q), 64'hDEF);
      tick("rst2");
      check("rst2_av_const", 64'(a_if.y_valid), 64'h0);

      // First cycle after reset: D3 captured
      rst = 1'b0;
      apply();
      tick("post_rst");
      check("post_rst_aq_const", 64'(a_if.y_q), 64'h44);
      check("post_rst_av_const", 64'(a_if.y_valid), 64'h1);

      // Single-bit selector: each select held 20 ns with in_valid=0
      a_v = 1'b0; c_v = 1'b0; b_v = 1'b0;
      for (int s = 0; s < 4; s++) begin
         b_s = 2'(s);
         apply();
         #1;
         check_comb("w1_sel");
         check("w1_bq_hold", 64'(b_if.y_q), 64'h0);
         #19;
      end
      check_regs("w1_hold");

      // Non-selected inputs toggle: Y must stay at D2
      a_s = 2'd2;
      for (int k = 0; k < 6; k++) begin
         a_d[0] = 64'($urandom & 32'hFF);
         a_d[1] = 64'($urandom & 32'hFF);
         a_d[3] = 64'($urandom & 32'hFF);
         apply();
         #1;
         check("nonsel_aY", 64'(a_if.Y), 64'h33);
         #9;
      end
      a_d[2] = 64'h5A;
      apply();
      #1;
      check("sel_change_aY", 64'(a_if.Y), 64'h5A);
      #9;

      // Back-to-back stream of four captures, S stepping 00..11
      a_d[0] = 64'h11; a_d[1] = 64'h22; a_d[2] = 64'h33; a_d[3] = 64'h44;
      @(posedge clk); #1;
      a_v = 1'b1;
      for (int s = 0; s < 4; s++) begin
         a_s = 2'(s);
         apply();
         tick("stream");
         check("stream_av_const", 64'(a_if.y_valid), 64'h1);
      end
      check("stream_last_const", 64'(a_if.y_q), 64'h44);
      a_v = 1'b0;
      apply();
      tick("stream_end");
      check("stream_end_av_const", 64'(a_if.y_valid), 64'h0);

      // Single pulse with S=01, then inputs wander with in_valid low
      a_s = 2'd1; a_v = 1'b1;
      apply();
      tick("pulse");
      a_v = 1'b0;
      for (int k = 0; k < 4; k++) begin
         randomize_inputs(1'b0);
         apply();
         tick("pulse_hold");
         check("pulse_hold_const", 64'(a_if.y_q), 64'h22);
      end

      // Reset in the middle of a stream, then resume
      a_v = 1'b1; b_v = 1'b1; c_v = 1'b1;
      for (int k = 0; k < 8; k++) begin
         rst = (k == 3);
         randomize_inputs(1'b0);
         apply();
         #1;
         check_comb("mid_rst");
         tick("mid_rst");
      end
      rst = 1'b0;

      // Randomized traffic with occasional resets
      for (int k = 0; k < 150; k++) begin
         rst = ($urandom_range(0, 19) == 0);
         randomize_inputs(1'b1);
         apply();
         #1;
         check_comb("rand");
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
